// File: rtl/t_math_wallace_pkg.sv
// Shared definitions for the Wallace multiplier issue controller: latency, ID sizing, issue tag.
package t_math_wallace_pkg;

   localparam int unsigned MUL_LATENCY = 3;

   function automatic int unsigned id_width(input int unsigned n);
      return $clog2(n);
   endfunction

   typedef struct packed {
      logic       valid;
      logic [2:0] id;
   } issue_tag_t;

endpackage

// File: rtl/t_math_wallace_rr.sv
// Combinational round-robin arbiter: first asserted request at or after ptr_i wins.
module t_math_wallace_rr
   import t_math_wallace_pkg::*;
#(
   parameter  int unsigned NREQ = 4,
   localparam int unsigned IdW  = id_width(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IdW-1:0]  ptr_i,
   output logic [NREQ-1:0] grant_o,
   output logic [IdW-1:0]  winner_o,
   output logic            any_o
);

   logic [IdW:0]   sum;
   logic [IdW-1:0] idx;
   logic           found;

   always_comb begin
      grant_o  = '0;
      winner_o = '0;
      found    = 1'b0;
      sum      = '0;
      idx      = '0;
      for (int k = 0; k < int'(NREQ); k++) begin
         // Candidate index (ptr + k) mod NREQ without a divider.
         sum = {1'b0, ptr_i} + (IdW+1)'(k);
         if (sum >= (IdW+1)'(NREQ)) begin
            sum = sum - (IdW+1)'(NREQ);
         end
         idx = sum[IdW-1:0];
         if (!found && req_i[idx]) begin
            found        = 1'b1;
            winner_o     = idx;
            grant_o[idx] = 1'b1;
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/t_math_wallace_arb.sv
// Round-robin issue controller sharing one pipelined Wallace multiplier among NREQ requesters.
module t_math_wallace_arb
   import t_math_wallace_pkg::*;
#(
   parameter  int unsigned NREQ    = 4,
   parameter  int unsigned WIDTH   = 32,
   parameter  int unsigned LATENCY = MUL_LATENCY,
   localparam int unsigned IdW     = id_width(NREQ)
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic [NREQ-1:0]       req_valid_i,
   input  logic [NREQ-1:0]       req_negate_i,
   input  logic [NREQ*WIDTH-1:0] req_a_i,
   input  logic [NREQ*WIDTH-1:0] req_b_i,
   output logic [NREQ-1:0]       req_ready_o,
   output logic                  mul_enable_o,
   output logic                  mul_negate_o,
   output logic [WIDTH-1:0]      mul_datA_o,
   output logic [WIDTH-1:0]      mul_datB_o,
   input  logic [2*WIDTH:0]      mul_product_d3_i,
   output logic                  rsp_valid_o,
   output logic [IdW-1:0]        rsp_id_o,
   output logic [2*WIDTH-1:0]    rsp_product_o,
   output logic [31:0]           issue_count_o
);

   logic [IdW-1:0]  ptr_q, ptr_d;
   logic [31:0]     cnt_q, cnt_d;
   issue_tag_t [LATENCY-1:0] pipe_q, pipe_d;
   issue_tag_t      tag_in;

   logic [NREQ-1:0] grant;
   logic [IdW-1:0]  winner;
   logic            any_req;
   logic            accept;

   t_math_wallace_rr #(
      .NREQ (NREQ)
   ) u_rr (
      .req_i    (req_valid_i),
      .ptr_i    (ptr_q),
      .grant_o  (grant),
      .winner_o (winner),
      .any_o    (any_req)
   );

   // Reset overrides arbitration so nothing is accepted during the reset cycle.
   assign accept = any_req & ~reset_i;

   always_comb begin
      ptr_d = ptr_q;
      if (accept) begin
         ptr_d = (winner == IdW'(NREQ - 1)) ? '0 : winner + IdW'(1);
      end
   end

   always_comb begin
      tag_in.valid = accept;
      tag_in.id    = accept ? 3'(winner) : 3'd0;
      pipe_d[0]    = tag_in;
      for (int unsigned i = 1; i < LATENCY; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (accept && (cnt_q != 32'hFFFF_FFFF)) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ptr_q  <= '0;
         pipe_q <= '0;
         cnt_q  <= '0;
      end else begin
         ptr_q  <= ptr_d;
         pipe_q <= pipe_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      req_ready_o  = accept ? grant : '0;
      mul_enable_o = accept;
      mul_negate_o = 1'b0;
      mul_datA_o   = '0;
      mul_datB_o   = '0;
      if (accept) begin
         mul_negate_o = req_negate_i[winner];
         mul_datA_o   = req_a_i[winner*WIDTH +: WIDTH];
         mul_datB_o   = req_b_i[winner*WIDTH +: WIDTH];
      end
   end

   // The multiplier datapath is never reset; only the tag valid qualifies its output.
   assign rsp_valid_o   = pipe_q[LATENCY-1].valid & ~reset_i;
   assign rsp_id_o      = reset_i ? '0 : pipe_q[LATENCY-1].id[IdW-1:0];
   assign rsp_product_o = mul_product_d3_i[2*WIDTH-1:0];
   assign issue_count_o = cnt_q;

   logic unused_bits;
   assign unused_bits = ^{mul_product_d3_i[2*WIDTH], pipe_q[LATENCY-1].id};

endmodule
